// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sequencer: default widths and the FSM state encoding.
package pwm_pkg;

    localparam int DEF_DATABITS      = 8;
    localparam int DEF_PRESCALE_BITS = 8;
    localparam int DEF_RAMP_STEP     = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_e;

endpackage

// File: rtl/pwm_sequencer_if.sv
// Duty-cycle update channel: valid/ready handshake carrying the requested compare value.
interface pwm_sequencer_if
    import pwm_pkg::*;
#(
    parameter int DATABITS = DEF_DATABITS
);

    logic [DATABITS-1:0] DutyData;
    logic                DutyValid;
    logic                DutyReady;

    modport master (output DutyData, output DutyValid, input  DutyReady);
    modport slave  (input  DutyData, input  DutyValid, output DutyReady);

endinterface

// File: rtl/pwm_carrier.sv
// Sawtooth carrier: prescaler, Saw counter and registered PeriodStart pulse.
module pwm_carrier
    import pwm_pkg::*;
#(
    parameter int DATABITS      = DEF_DATABITS,
    parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     run,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic [DATABITS-1:0]      saw,
    output logic                     period_start,
    output logic                     wrap
);

    logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    logic [DATABITS-1:0]      saw_q, saw_d;
    logic                     period_start_q, period_start_d;
    logic                     tick;

    // wrap is the combinational boundary the sequencer uses to update on the same edge Saw returns to 0
    always_comb begin
        tick           = run && (pre_cnt_q >= prescale);
        wrap           = tick && (saw_q == {DATABITS{1'b1}});
        pre_cnt_d      = pre_cnt_q;
        saw_d          = saw_q;
        period_start_d = 1'b0;
        if (!run) begin
            pre_cnt_d = '0;
            saw_d     = '0;
        end else begin
            if (tick) begin
                pre_cnt_d = '0;
                saw_d     = saw_q + 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
            period_start_d = wrap;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pre_cnt_q      <= '0;
            saw_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            saw_q          <= saw_d;
            period_start_q <= period_start_d;
        end
    end

    assign saw          = saw_q;
    assign period_start = period_start_q;

endmodule

// File: rtl/pwm_sequencer.sv
// PWM sequencer: shadowed duty updates applied at carrier boundaries, with soft-start/soft-stop ramps.
module pwm_sequencer
    import pwm_pkg::*;
#(
    parameter int DATABITS      = DEF_DATABITS,
    parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
    parameter int RAMP_STEP     = DEF_RAMP_STEP
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    input  logic [PRESCALE_BITS-1:0] Prescale,
    pwm_sequencer_if.slave           duty,
    output logic [DATABITS-1:0]      Saw,
    output logic [DATABITS-1:0]      Signal,
    output logic                     PeriodStart,
    output logic                     Active
);

    localparam logic [DATABITS:0] STEP = (DATABITS+1)'(RAMP_STEP);
    localparam logic [DATABITS:0] FULL = {1'b0, {DATABITS{1'b1}}};

    state_e              state_q, state_d;
    logic [DATABITS-1:0] signal_q, signal_d;
    logic [DATABITS-1:0] target_q, target_d;
    logic [DATABITS-1:0] shadow_q, shadow_d;
    logic                pending_q, pending_d;

    logic                wrap;
    logic                run;
    logic [DATABITS-1:0] eff_target;
    logic [DATABITS:0]   sig_w, tgt_w, up_sum, up_val, down_val;
    logic [DATABITS-1:0] ramp_val, stop_val;

    assign run = (state_q != ST_IDLE);

    pwm_carrier #(
        .DATABITS      (DATABITS),
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_carrier (
        .Clk          (Clk),
        .Rst          (Rst),
        .run          (run),
        .prescale     (Prescale),
        .saw          (Saw),
        .period_start (PeriodStart),
        .wrap         (wrap)
    );

    // A value still waiting in the shadow is the one that lands at this boundary
    always_comb begin
        eff_target = pending_q ? shadow_q : target_q;
        sig_w      = {1'b0, signal_q};
        tgt_w      = {1'b0, eff_target};
        up_sum     = sig_w + STEP;
        if (up_sum > FULL) up_sum = FULL;
        up_val = sig_w;
        if (tgt_w > sig_w) begin
            up_val = (up_sum > tgt_w) ? tgt_w : up_sum;
        end else if (tgt_w < sig_w) begin
            up_val = (sig_w < tgt_w + STEP) ? tgt_w : sig_w - STEP;
        end
        down_val = (sig_w < STEP) ? '0 : sig_w - STEP;
        ramp_val = up_val[DATABITS-1:0];
        stop_val = down_val[DATABITS-1:0];
    end

    always_comb begin
        state_d   = state_q;
        signal_d  = signal_q;
        target_d  = target_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        if (duty.DutyValid && !pending_q) begin
            shadow_d  = duty.DutyData;
            pending_d = 1'b1;
        end
        if (pending_q && (wrap || state_q == ST_IDLE)) begin
            target_d  = shadow_q;
            pending_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                signal_d = '0;
                if (En) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (wrap) begin
                    signal_d = ramp_val;
                    if (ramp_val == eff_target) state_d = ST_RUN;
                end
                if (!En) state_d = ST_RAMP_DOWN;
            end
            ST_RUN: begin
                if (wrap) signal_d = eff_target;
                if (!En) state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (wrap) begin
                    signal_d = stop_val;
                    if (stop_val == '0) state_d = ST_IDLE;
                end
                if (En) state_d = ST_RAMP_UP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            signal_q  <= '0;
            target_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            signal_q  <= signal_d;
            target_q  <= target_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign duty.DutyReady = !pending_q;
    assign Signal         = signal_q;
    assign Active         = run;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed testbench for pwm_sequencer (DATABITS=8, RAMP_STEP=4).
module tb_pwm_sequencer;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic [7:0] Prescale;
    logic [7:0] Saw;
    logic [7:0] Signal;
    logic       PeriodStart;
    logic       Active;

    int total = 0;
    int bad   = 0;

    pwm_sequencer_if #(.DATABITS(8)) duty_bus ();

    pwm_sequencer #(
        .DATABITS      (8),
        .PRESCALE_BITS (8),
        .RAMP_STEP     (4)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .En          (En),
        .Prescale    (Prescale),
        .duty        (duty_bus),
        .Saw         (Saw),
        .Signal      (Signal),
        .PeriodStart (PeriodStart),
        .Active      (Active)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Bounded wait for the next PeriodStart, sampled on falling edges
    task automatic wait_ps(input int budget, output int waited, output bit found);
        waited = 0;
        found  = 1'b0;
        while (waited < budget && !found) begin
            @(negedge Clk);
            waited++;
            if (PeriodStart === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        #2 Rst = 1'b0;
        #1;
        total++; if (Saw !== 8'd0) begin bad++; $display("[TB] FAIL reset_saw got=%0d want=0", Saw); end
        total++; if (Signal !== 8'd0) begin bad++; $display("[TB] FAIL reset_signal got=%0d want=0", Signal); end
        total++; if (PeriodStart !== 1'b0) begin bad++; $display("[TB] FAIL reset_ps got=%b want=0", PeriodStart); end
        total++; if (Active !== 1'b0) begin bad++; $display("[TB] FAIL reset_active got=%b want=0", Active); end
        total++; if (duty_bus.DutyReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", duty_bus.DutyReady); end
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        total++; if (Active !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_active got=%b want=0", Active); end
    endtask

    task automatic test_ramp_up();
        int  waited;
        bit  found;
        @(negedge Clk);
        duty_bus.DutyData  = 8'd100;
        duty_bus.DutyValid = 1'b1;
        total++; if (duty_bus.DutyReady !== 1'b1) begin bad++; $display("[TB] FAIL ru_ready_before got=%b want=1", duty_bus.DutyReady); end
        @(negedge Clk);
        duty_bus.DutyValid = 1'b0;
        total++; if (duty_bus.DutyReady !== 1'b0) begin bad++; $display("[TB] FAIL ru_ready_pending got=%b want=0", duty_bus.DutyReady); end
        @(negedge Clk);
        total++; if (duty_bus.DutyReady !== 1'b1) begin bad++; $display("[TB] FAIL ru_ready_idle_move got=%b want=1", duty_bus.DutyReady); end
        En = 1'b1;
        @(negedge Clk);
        total++; if (Active !== 1'b1) begin bad++; $display("[TB] FAIL ru_active got=%b want=1", Active); end
        total++; if (Signal !== 8'd0) begin bad++; $display("[TB] FAIL ru_signal_start got=%0d want=0", Signal); end
        for (int k = 1; k <= 25; k++) begin
            wait_ps(300, waited, found);
            total++; if (!found) begin bad++; $display("[TB] FAIL ru_ps_timeout step=%0d got=none want=pulse", k); end
            total++; if (Signal !== 8'(4 * k)) begin bad++; $display("[TB] FAIL ru_signal step=%0d got=%0d want=%0d", k, Signal, 4 * k); end
            if (k > 1) begin
                total++; if (waited != 256) begin bad++; $display("[TB] FAIL ru_period step=%0d got=%0d want=256", k, waited); end
            end
        end
        total++; if (Saw !== 8'd0) begin bad++; $display("[TB] FAIL ru_saw_at_ps got=%0d want=0", Saw); end
        wait_ps(300, waited, found);
        total++; if (!found) begin bad++; $display("[TB] FAIL ru_run_timeout got=none want=pulse"); end
        total++; if (Signal !== 8'd100) begin bad++; $display("[TB] FAIL ru_run_hold got=%0d want=100", Signal); end
    endtask

    task automatic test_update_midrun();
        int  n;
        bit  found;
        bit  held_ok;
        repeat (100) @(negedge Clk);
        duty_bus.DutyData  = 8'd200;
        duty_bus.DutyValid = 1'b1;
        total++; if (duty_bus.DutyReady !== 1'b1) begin bad++; $display("[TB] FAIL up_ready_before got=%b want=1", duty_bus.DutyReady); end
        @(negedge Clk);
        duty_bus.DutyValid = 1'b0;
        total++; if (duty_bus.DutyReady !== 1'b0) begin bad++; $display("[TB] FAIL up_ready_after got=%b want=0", duty_bus.DutyReady); end
        n = 0; found = 1'b0; held_ok = 1'b1;
        while (n < 300 && !found) begin
            @(negedge Clk);
            n++;
            if (PeriodStart === 1'b1) found = 1'b1;
            else if (Signal !== 8'd100 || duty_bus.DutyReady !== 1'b0) held_ok = 1'b0;
        end
        total++; if (!found) begin bad++; $display("[TB] FAIL up_ps_timeout got=none want=pulse"); end
        total++; if (!held_ok) begin bad++; $display("[TB] FAIL up_hold got=changed want=signal100_ready0"); end
        total++; if (Signal !== 8'd200) begin bad++; $display("[TB] FAIL up_applied got=%0d want=200", Signal); end
        total++; if (duty_bus.DutyReady !== 1'b1) begin bad++; $display("[TB] FAIL up_ready_rise got=%b want=1", duty_bus.DutyReady); end
    endtask

    task automatic test_hold_valid();
        int  n;
        int  waited;
        bit  found;
        bit  held_ok;
        repeat (50) @(negedge Clk);
        duty_bus.DutyData  = 8'd150;
        duty_bus.DutyValid = 1'b1;
        @(negedge Clk);
        total++; if (duty_bus.DutyReady !== 1'b0) begin bad++; $display("[TB] FAIL hv_ready_pending got=%b want=0", duty_bus.DutyReady); end
        duty_bus.DutyData = 8'd50;
        n = 0; found = 1'b0; held_ok = 1'b1;
        while (n < 300 && !found) begin
            @(negedge Clk);
            n++;
            if (PeriodStart === 1'b1) found = 1'b1;
            else if (Signal !== 8'd200 || duty_bus.DutyReady !== 1'b0) held_ok = 1'b0;
        end
        total++; if (!found) begin bad++; $display("[TB] FAIL hv_ps_timeout got=none want=pulse"); end
        total++; if (!held_ok) begin bad++; $display("[TB] FAIL hv_hold got=changed want=signal200_ready0"); end
        total++; if (Signal !== 8'd150) begin bad++; $display("[TB] FAIL hv_first_value got=%0d want=150", Signal); end
        total++; if (duty_bus.DutyReady !== 1'b1) begin bad++; $display("[TB] FAIL hv_ready_rise got=%b want=1", duty_bus.DutyReady); end
        @(negedge Clk);
        total++; if (duty_bus.DutyReady !== 1'b0) begin bad++; $display("[TB] FAIL hv_taken got=%b want=0", duty_bus.DutyReady); end
        duty_bus.DutyValid = 1'b0;
        wait_ps(300, waited, found);
        total++; if (!found) begin bad++; $display("[TB] FAIL hv_ps2_timeout got=none want=pulse"); end
        total++; if (Signal !== 8'd50) begin bad++; $display("[TB] FAIL hv_second_value got=%0d want=50", Signal); end
    endtask

    task automatic test_ramp_down();
        int         waited;
        bit         found;
        bit         quiet_ok;
        logic [7:0] expect_seq [3];
        expect_seq[0] = 8'd6;
        expect_seq[1] = 8'd2;
        expect_seq[2] = 8'd0;
        repeat (50) @(negedge Clk);
        duty_bus.DutyData  = 8'd10;
        duty_bus.DutyValid = 1'b1;
        @(negedge Clk);
        duty_bus.DutyValid = 1'b0;
        wait_ps(300, waited, found);
        total++; if (Signal !== 8'd10) begin bad++; $display("[TB] FAIL rd_start got=%0d want=10", Signal); end
        En = 1'b0;
        @(negedge Clk);
        total++; if (Active !== 1'b1) begin bad++; $display("[TB] FAIL rd_active got=%b want=1", Active); end
        for (int k = 0; k < 3; k++) begin
            wait_ps(300, waited, found);
            total++; if (!found) begin bad++; $display("[TB] FAIL rd_ps_timeout step=%0d got=none want=pulse", k); end
            total++; if (Signal !== expect_seq[k]) begin bad++; $display("[TB] FAIL rd_signal step=%0d got=%0d want=%0d", k, Signal, expect_seq[k]); end
        end
        total++; if (Active !== 1'b0) begin bad++; $display("[TB] FAIL rd_idle_active got=%b want=0", Active); end
        quiet_ok = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk);
            if (PeriodStart !== 1'b0 || Saw !== 8'd0 || Active !== 1'b0) quiet_ok = 1'b0;
        end
        total++; if (!quiet_ok) begin bad++; $display("[TB] FAIL rd_idle_quiet got=activity want=none"); end
    endtask

    task automatic test_prescale();
        int  waited;
        bit  found;
        Prescale = 8'd3;
        En       = 1'b1;
        wait_ps(1100, waited, found);
        total++; if (!found) begin bad++; $display("[TB] FAIL ps_first_timeout got=none want=pulse"); end
        total++; if (Signal !== 8'd4) begin bad++; $display("[TB] FAIL ps_signal1 got=%0d want=4", Signal); end
        repeat (3) @(negedge Clk);
        total++; if (Saw !== 8'd0) begin bad++; $display("[TB] FAIL ps_saw3 got=%0d want=0", Saw); end
        @(negedge Clk);
        total++; if (Saw !== 8'd1) begin bad++; $display("[TB] FAIL ps_saw4 got=%0d want=1", Saw); end
        repeat (4) @(negedge Clk);
        total++; if (Saw !== 8'd2) begin bad++; $display("[TB] FAIL ps_saw8 got=%0d want=2", Saw); end
        wait_ps(1100, waited, found);
        total++; if (!found) begin bad++; $display("[TB] FAIL ps_second_timeout got=none want=pulse"); end
        total++; if (waited + 8 != 1024) begin bad++; $display("[TB] FAIL ps_period got=%0d want=1024", waited + 8); end
        total++; if (Signal !== 8'd8) begin bad++; $display("[TB] FAIL ps_signal2 got=%0d want=8", Signal); end
    endtask

    task automatic test_reset_mid_ramp();
        int  waited;
        bit  found;
        bit  idle_ok;
        repeat (20) @(negedge Clk);
        duty_bus.DutyData  = 8'd77;
        duty_bus.DutyValid = 1'b1;
        @(negedge Clk);
        duty_bus.DutyValid = 1'b0;
        #2 Rst = 1'b0;
        #1;
        total++; if (Saw !== 8'd0) begin bad++; $display("[TB] FAIL mr_saw got=%0d want=0", Saw); end
        total++; if (Signal !== 8'd0) begin bad++; $display("[TB] FAIL mr_signal got=%0d want=0", Signal); end
        total++; if (PeriodStart !== 1'b0) begin bad++; $display("[TB] FAIL mr_ps got=%b want=0", PeriodStart); end
        total++; if (Active !== 1'b0) begin bad++; $display("[TB] FAIL mr_active got=%b want=0", Active); end
        total++; if (duty_bus.DutyReady !== 1'b1) begin bad++; $display("[TB] FAIL mr_ready got=%b want=1", duty_bus.DutyReady); end
        En       = 1'b0;
        Prescale = 8'd0;
        @(negedge Clk);
        Rst = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (Active !== 1'b0 || Saw !== 8'd0 || PeriodStart !== 1'b0) idle_ok = 1'b0;
        end
        total++; if (!idle_ok) begin bad++; $display("[TB] FAIL mr_stays_idle got=activity want=idle"); end
        En = 1'b1;
        wait_ps(300, waited, found);
        total++; if (!found) begin bad++; $display("[TB] FAIL mr_ps_timeout got=none want=pulse"); end
        total++; if (Signal !== 8'd0) begin bad++; $display("[TB] FAIL mr_dropped_shadow got=%0d want=0", Signal); end
        total++; if (Active !== 1'b1) begin bad++; $display("[TB] FAIL mr_restart_active got=%b want=1", Active); end
    endtask

    initial begin
        Rst                = 1'b1;
        En                 = 1'b0;
        Prescale           = 8'd0;
        duty_bus.DutyData  = 8'd0;
        duty_bus.DutyValid = 1'b0;
        test_reset();
        test_ramp_up();
        test_update_midrun();
        test_hold_valid();
        test_ramp_down();
        test_prescale();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
